// File: rtl/alu_arb_pkg.sv
// alu_arb_pkg: shared state, requester index and opcode definitions for alu_arbiter
package alu_arb_pkg;
  typedef enum logic [1:0] {IDLE, EXEC, RESP} arb_state_t;
  typedef logic req_idx_t;
  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_SLL = 3'd2;
  localparam logic [2:0] OP_SRL = 3'd3;
  localparam logic [2:0] OP_AND = 3'd4;
  localparam logic [2:0] OP_OR  = 3'd5;
  localparam logic [2:0] OP_XOR = 3'd6;
  localparam logic [2:0] OP_JNZ = 3'd7;
endpackage

// File: rtl/alu_arbiter_rr_picker.sv
// rr_picker: 2-way grant, round robin or fixed priority when ALU_ARB_FIXED_PRIO_EN is defined
module rr_picker
  import alu_arb_pkg::*;
(
  input  logic [1:0] valid_i,
  input  req_idx_t   last_grant_i,
  output logic       gnt_o,
  output req_idx_t   idx_o
);
  assign gnt_o = |valid_i;
`ifdef ALU_ARB_FIXED_PRIO_EN
  logic unused_last;
  assign unused_last = last_grant_i;
  assign idx_o = !valid_i[0];
`else
  assign idx_o = &valid_i ? !last_grant_i : valid_i[1];
`endif
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: serialises two requesters onto one external ALU (ALU_ARB_FIXED_PRIO_EN selects fixed priority)
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int reg_width = 8,
  parameter int op_width  = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req0_valid,
  input  logic                 req1_valid,
  output logic                 req0_ready,
  output logic                 req1_ready,
  input  logic [reg_width-1:0] req0_ra,
  input  logic [reg_width-1:0] req0_rb,
  input  logic [reg_width-1:0] req1_ra,
  input  logic [reg_width-1:0] req1_rb,
  input  logic [op_width-1:0]  req0_op,
  input  logic [op_width-1:0]  req1_op,
  output logic                 resp0_valid,
  output logic                 resp1_valid,
  input  logic                 resp0_ready,
  input  logic                 resp1_ready,
  output logic [reg_width-1:0] res_out,
  output logic [reg_width-1:0] car_out,
  output logic                 zero,
  output logic                 jump,
  output logic [reg_width-1:0] alu_ra,
  output logic [reg_width-1:0] alu_rb,
  output logic [op_width-1:0]  alu_op,
  input  logic [reg_width-1:0] alu_res,
  input  logic [reg_width-1:0] alu_car,
  input  logic                 alu_zero,
  input  logic                 alu_jump
);
  arb_state_t           state_q;
  req_idx_t             owner_q, last_q, idx;
  logic                 gnt, idle_gnt;
  logic                 resp0_q, resp1_q, zero_q, jump_q;
  logic [reg_width-1:0] ra_q, rb_q, res_q, car_q;
  logic [op_width-1:0]  op_q;
  rr_picker u_pick (
    .valid_i      ({req1_valid, req0_valid}),
    .last_grant_i (last_q),
    .gnt_o        (gnt),
    .idx_o        (idx)
  );
  // readies are gated by reset so nothing is accepted while the block is being cleared
  assign idle_gnt    = !reset && state_q == IDLE && gnt;
  assign req0_ready  = idle_gnt && !idx;
  assign req1_ready  = idle_gnt && idx;
  assign resp0_valid = resp0_q;
  assign resp1_valid = resp1_q;
  assign res_out     = res_q;
  assign car_out     = car_q;
  assign zero        = zero_q;
  assign jump        = jump_q;
  assign alu_ra      = ra_q;
  assign alu_rb      = rb_q;
  assign alu_op      = op_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      ra_q    <= '0;
      rb_q    <= '0;
      op_q    <= '0;
      res_q   <= '0;
      car_q   <= '0;
      zero_q  <= 1'b0;
      jump_q  <= 1'b0;
      resp0_q <= 1'b0;
      resp1_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (gnt) begin
          ra_q    <= idx ? req1_ra : req0_ra;
          rb_q    <= idx ? req1_rb : req0_rb;
          op_q    <= idx ? req1_op : req0_op;
          owner_q <= idx;
          last_q  <= idx;
          state_q <= EXEC;
        end
        EXEC: begin
          res_q   <= alu_res;
          car_q   <= alu_car;
          zero_q  <= alu_zero;
          jump_q  <= alu_jump;
          resp0_q <= !owner_q;
          resp1_q <= owner_q;
          state_q <= RESP;
        end
        RESP: if (owner_q ? resp1_ready : resp0_ready) begin
          resp0_q <= 1'b0;
          resp1_q <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed and random checks of alu_arbiter against a transaction-level model
module tb_alu_arbiter;
  import alu_arb_pkg::*;
  logic       clk = 1'b0, reset = 1'b1;
  logic       req0_valid = 1'b0, req1_valid = 1'b0, req0_ready, req1_ready;
  logic [7:0] req0_ra = '0, req0_rb = '0, req1_ra = '0, req1_rb = '0;
  logic [2:0] req0_op = '0, req1_op = '0;
  logic       resp0_valid, resp1_valid, resp0_ready = 1'b0, resp1_ready = 1'b0;
  logic [7:0] res_out, car_out, alu_ra, alu_rb, alu_res, alu_car;
  logic       zero, jump, alu_zero, alu_jump;
  logic [2:0] alu_op;
  int n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.reg_width(8), .op_width(3)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .req0_ra(req0_ra), .req0_rb(req0_rb), .req1_ra(req1_ra), .req1_rb(req1_rb),
    .req0_op(req0_op), .req1_op(req1_op),
    .resp0_valid(resp0_valid), .resp1_valid(resp1_valid),
    .resp0_ready(resp0_ready), .resp1_ready(resp1_ready),
    .res_out(res_out), .car_out(car_out), .zero(zero), .jump(jump),
    .alu_ra(alu_ra), .alu_rb(alu_rb), .alu_op(alu_op),
    .alu_res(alu_res), .alu_car(alu_car), .alu_zero(alu_zero), .alu_jump(alu_jump)
  );

  // reference ALU that sits beside the arbiter
  function automatic logic [17:0] alu_f(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    logic [7:0] r, c;
    logic       j;
    s = '0; r = a; c = '0; j = 1'b0;
    case (op)
      OP_ADD: begin s = {1'b0, a} + {1'b0, b}; r = s[7:0]; c = {7'b0, s[8]}; end
      OP_SUB: begin r = a - b; c = {7'b0, a < b}; end
      OP_SLL: r = a << b;
      OP_SRL: r = a >> b;
      OP_AND: r = a & b;
      OP_OR:  r = a | b;
      OP_XOR: r = a ^ b;
      default: begin r = a; j = a != 8'h00; end
    endcase
    return {r, c, r == 8'h00, j};
  endfunction

  assign {alu_res, alu_car, alu_zero, alu_jump} = alu_f(alu_op, alu_ra, alu_rb);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // transaction-level model: one request in flight, response two cycles after acceptance
  logic       started = 1'b0, m_busy = 1'b0, m_exec = 1'b0, m_own = 1'b0, m_last = 1'b1;
  logic       acc0 = 1'b0, acc1 = 1'b0, e_rv0 = 1'b0, e_rv1 = 1'b0, e_z = 1'b0, e_j = 1'b0;
  logic [7:0] e_ra = '0, e_rb = '0, e_res = '0, e_car = '0;
  logic [2:0] e_op = '0;
  logic       er0, er1;
  int         gq[$];

  always_comb begin
    er0 = 1'b0;
    er1 = 1'b0;
    if (!reset && !m_busy) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      er0 = req0_valid;
      er1 = req1_valid && !req0_valid;
`else
      er0 = req0_valid && (!req1_valid || m_last == 1'b1);
      er1 = req1_valid && (!req0_valid || m_last == 1'b0);
`endif
    end
  end

  always @(posedge clk) begin
    logic [17:0] r;
    started = 1'b1;
    acc0 = 1'b0;
    acc1 = 1'b0;
    if (reset) begin
      m_busy = 1'b0; m_exec = 1'b0; m_own = 1'b0; m_last = 1'b1;
      e_ra = '0; e_rb = '0; e_op = '0; e_res = '0; e_car = '0;
      e_z = 1'b0; e_j = 1'b0; e_rv0 = 1'b0; e_rv1 = 1'b0;
    end else if (!m_busy) begin
      if (er0 || er1) begin
        m_own = er1;
        e_ra = m_own ? req1_ra : req0_ra;
        e_rb = m_own ? req1_rb : req0_rb;
        e_op = m_own ? req1_op : req0_op;
        m_last = m_own;
        m_busy = 1'b1;
        m_exec = 1'b1;
        acc0 = !m_own;
        acc1 = m_own;
        gq.push_back(int'(m_own));
      end
    end else if (m_exec) begin
      r = alu_f(e_op, e_ra, e_rb);
      {e_res, e_car, e_z, e_j} = r;
      e_rv0 = !m_own;
      e_rv1 = m_own;
      m_exec = 1'b0;
    end else if (m_own ? resp1_ready : resp0_ready) begin
      e_rv0 = 1'b0;
      e_rv1 = 1'b0;
      m_busy = 1'b0;
    end
  end

  always @(negedge clk) if (started) begin
    chk("req0_ready", req0_ready, er0);
    chk("req1_ready", req1_ready, er1);
    chk("resp0_valid", resp0_valid, e_rv0);
    chk("resp1_valid", resp1_valid, e_rv1);
    chk("res_out", res_out, e_res);
    chk("car_out", car_out, e_car);
    chk("zero", zero, e_z);
    chk("jump", jump, e_j);
    chk("alu_ra", alu_ra, e_ra);
    chk("alu_rb", alu_rb, e_rb);
    chk("alu_op", alu_op, e_op);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    resp0_ready = 1'b0; resp1_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  int exp_g[4];
  int rises;

  initial begin
`ifdef ALU_ARB_FIXED_PRIO_EN
    exp_g = '{0, 0, 0, 0};
`else
    exp_g = '{0, 1, 0, 1};
`endif
    // reset release, then a single SRL from requester 0
    do_reset();
    chk("lit_idle_ready0", req0_ready, 0);
    chk("lit_idle_res", res_out, 0);
    req0_valid = 1'b1; req0_op = OP_SRL; req0_ra = 8'hF0; req0_rb = 8'd2; resp0_ready = 1'b1;
    #1;
    chk("lit_srl_ready0", req0_ready, 1);
    chk("lit_srl_ready1", req1_ready, 0);
    tick();
    req0_valid = 1'b0;
    chk("lit_srl_alu_ra", alu_ra, 8'hF0);
    chk("lit_srl_alu_op", alu_op, 3'd3);
    tick();
    chk("lit_srl_resp0", resp0_valid, 1);
    chk("lit_srl_res", res_out, 8'h3C);
    chk("lit_srl_resp1", resp1_valid, 0);
    tick();
    chk("lit_srl_done", resp0_valid, 0);
    chk("lit_srl_hold", res_out, 8'h3C);
    // both requesters continuously valid: grant order
    do_reset();
    gq.delete();
    req0_valid = 1'b1; req0_op = OP_ADD; req0_ra = 8'h11; req0_rb = 8'h22;
    req1_valid = 1'b1; req1_op = OP_XOR; req1_ra = 8'h0F; req1_rb = 8'hFF;
    resp0_ready = 1'b1; resp1_ready = 1'b1;
    #1;
    chk("lit_tie_ready0", req0_ready, 1);
    chk("lit_tie_ready1", req1_ready, 0);
    repeat (3) tick();
`ifdef ALU_ARB_FIXED_PRIO_EN
    chk("lit_n3_ready0", req0_ready, 1);
`else
    chk("lit_n3_ready1", req1_ready, 1);
`endif
    repeat (9) tick();
    chk("lit_grant_count", gq.size() >= 4, 1);
    for (int i = 0; i < 4 && i < gq.size(); i++) chk("lit_grant_order", gq[i], exp_g[i]);
    // requester 1 response stalled for five cycles
    do_reset();
    req1_valid = 1'b1; req1_op = OP_ADD; req1_ra = 8'h80; req1_rb = 8'h90;
    resp0_ready = 1'b1;
    #1;
    chk("lit_stall_ready1", req1_ready, 1);
    tick();
    req1_valid = 1'b0;
    req0_valid = 1'b1; req0_op = OP_XOR; req0_ra = 8'h55; req0_rb = 8'hAA;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("lit_stall_resp1", resp1_valid, 1);
      chk("lit_stall_res", res_out, 8'h10);
      chk("lit_stall_car", car_out, 8'h01);
      chk("lit_stall_ready0", req0_ready, 0);
      chk("lit_stall_ready1", req1_ready, 0);
      if (i == 4) resp1_ready = 1'b1;
      tick();
    end
    resp1_ready = 1'b0;
    chk("lit_stall_idle_ready0", req0_ready, 1);
    chk("lit_stall_resp1_clr", resp1_valid, 0);
    tick();
    req0_valid = 1'b0;
    tick();
    tick();
    // reset while the request is in EXEC
    do_reset();
    req0_valid = 1'b1; req0_op = OP_ADD; req0_ra = 8'h01; req0_rb = 8'h02; resp0_ready = 1'b1;
    tick();
    req0_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    rises = 0;
    repeat (5) begin
      if (resp0_valid || resp1_valid) rises++;
      tick();
    end
    chk("lit_abort_no_resp", rises, 0);
    req0_valid = 1'b1; req0_op = OP_SRL; req0_ra = 8'hF0; req0_rb = 8'd4;
    tick();
    req0_valid = 1'b0;
    tick();
    chk("lit_srl4_resp0", resp0_valid, 1);
    chk("lit_srl4_res", res_out, 8'h0F);
    tick();
    // randomized traffic with occasional resets
    do_reset();
    repeat (3000) begin
      reset = $urandom_range(0, 199) == 0;
      if (!req0_valid || acc0) begin
        req0_valid = $urandom_range(0, 2) != 0;
        req0_ra = 8'($urandom); req0_rb = 8'($urandom); req0_op = 3'($urandom);
      end
      if (!req1_valid || acc1) begin
        req1_valid = $urandom_range(0, 2) != 0;
        req1_ra = 8'($urandom); req1_rb = 8'($urandom); req1_op = 3'($urandom);
      end
      resp0_ready = $urandom_range(0, 2) != 0;
      resp1_ready = $urandom_range(0, 2) != 0;
      tick();
    end
    reset = 1'b0;
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single combinational `alu` between two requesters (e.g. the fetch/decode path and the emulator's test/debug port). Each request is one valid/ready operand transfer and one valid/ready response. The block registers operands, drives the ALU for one cycle and captures its outputs. Requests are serialised under round-robin arbitration by a three-state FSM.

## Interface
- `reg_width`, 8, operand/result width
- `op_width`, 3, ALU opcode width

- `clk` in 1: rising-edge clock
- `reset` in 1: synchronous, active-high reset
- `req0_valid`, `req1_valid` in 1: request present
- `req0_ready`, `req1_ready` out 1: request accepted this cycle when valid & ready
- `req0_ra`, `req0_rb`, `req1_ra`, `req1_rb` in `reg_width`: operands
- `req0_op`, `req1_op` in `op_width`: opcode
- `resp0_valid`, `resp1_valid` out 1: response for requester 0/1 pending
- `resp0_ready`, `resp1_ready` in 1: requester consumes response
- `res_out`, `car_out` out `reg_width`: captured ALU result/carry (shared by both responses)
- `zero`, `jump` out 1: captured ALU flags
- `alu_ra`, `alu_rb` out `reg_width`; `alu_op` out `op_width`: registered drive to ALU
- `alu_res`, `alu_car` in `reg_width`; `alu_zero`, `alu_jump` in 1: ALU outputs

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE: the grant is computed combinationally from the valids and `last_grant`.
  - Only the granted requester sees ready=1.
  - Ready depends on the other requester's valid.
  - On handshake: latch ra/rb/op into `alu_*`, record `owner`, set `last_grant`=owner, go to EXEC.
- EXEC: the ALU evaluates the registered operands. At the end of the cycle, capture `alu_res`/`alu_car`/`alu_zero`/`alu_jump` into the outputs, assert `resp<owner>_valid`, go to RESP.
- RESP: hold outputs and `resp<owner>_valid` until `resp<owner>_ready`=1. On that edge, clear valid and go to IDLE. The other requester's `resp_ready` is ignored.
- Round robin:
  - Both valid: grant the requester ≠ `last_grant`.
  - One valid: grant it.
  - None valid: no grant, stay IDLE.
- Ready is 0 in EXEC and RESP. Valid may rise at any time and must be held until accepted; this is not checked.
- Reset values: state IDLE, `last_grant`=1 (req0 wins the first tie), `owner`=0. All outputs 0, including `alu_ra`/`alu_rb`/`alu_op` and both readies.
- Reset mid-operation (EXEC or RESP): in-flight request discarded, no response issued, all outputs 0 on the next cycle.
- No width extension or arithmetic inside the block; ALU values pass through bit-exact.

## Timing
- Request handshake at edge N → `alu_*` valid cycle N+1 → `resp_valid`/results valid cycle N+2.
- Minimum occupancy: 3 cycles per request (handshake, EXEC, RESP with immediate `resp_ready`). Peak throughput is 1 request per 3 cycles.
- `resp_ready` already high when `resp_valid` rises: response consumed at the end of that cycle, IDLE at N+3, next handshake possible at N+3.
- Results stay stable while `resp_valid`=1. After consumption they hold their last value until the next capture.
- `req*_ready` is combinational from state/valids/`last_grant`. All other outputs are registered.

## Configuration
- `ALU_ARB_FIXED_PRIO_EN` defined: fixed priority, req0 always wins when both are valid. `last_grant` is still tracked but not used for the decision.
- Undefined (default): round robin as above.

## Structure
- Package `alu_arb_pkg`:
  - state enum `arb_state_t` {IDLE, EXEC, RESP}
  - requester-index type
  - opcode constants used by benches, including `OP_SRL`=3'd3
- Sub-module `rr_picker`: 2-way combinational grant from `valid[1:0]` and `last_grant`; honours `ALU_ARB_FIXED_PRIO_EN`.
- The ALU is instantiated beside the arbiter at the top level, not inside it.

## Test plan
- Reset held 2 cycles, then released → all outputs 0, `req0_ready`=1 only once `req0_valid`=1.
- req0 SRL (op=3, ra=8'hF0, rb=2), resp0_ready=1 → `resp0_valid` at N+2 with `res_out`=8'h3C; `resp1_valid` stays 0.
- Both valid at the first cycle after reset → req0 served first, req1 handshakes at N+3. With both re-asserted, grants alternate 0,1,0,1. Under `ALU_ARB_FIXED_PRIO_EN`: 0,0,0.
- `resp1_ready` held 0 for 5 cycles in RESP → `res_out`/flags stable, both readies 0, req0 stalled. One cycle after `resp1_ready`=1 the state returns to IDLE.
- Reset asserted during EXEC → no `resp_valid` ever rises for that request. The next request completes normally.
- SRL ra=8'hF0, rb=4 → `res_out`=8'h0F.
